// File: rtl/multiword_adder_ctrl.sv
// multiword_adder_ctrl
//   Computes a W = N*K bit two's-complement add or subtract by running one
//   N-bit ripple-carry adder over K cycles, one slice per cycle, least
//   significant slice first. The carry between slices is held in a register.
//   Operands come in and the result goes out over valid/ready handshakes.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands and op presented
//   in_ready   accepting operands (IDLE only)
//   op_a       operand A, W bits
//   op_b       operand B, W bits
//   sub        0: A+B, 1: A-B
//   out_valid  result available (DONE only)
//   out_ready  consumer takes result
//   result     registered W-bit sum/difference
//   cout       carry out of bit W-1 (for subtract, 1 means no borrow)
//   overflow   signed overflow of the W-bit operation
//   busy       RUN or DONE
module multiword_adder_ctrl #(
  parameter int N = 32,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] op_a,
  input  logic [N*K-1:0] op_b,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] result,
  output logic           cout,
  output logic           overflow,
  output logic           busy
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state;
  logic [N*K-1:0]   a_reg;
  logic [N*K-1:0]   b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;

  logic [N-1:0]     slice_a;
  logic [N-1:0]     slice_b;
  logic [N-1:0]     slice_sum;
  logic             slice_cout;
  logic             slice_ovf;

  // N-bit ripple-carry adder. Overflow uses the sign rule on the addends,
  // so for subtract it sees the already-inverted B.
  function automatic logic [N+1:0] rca(input logic [N-1:0] a,
                                       input logic [N-1:0] b,
                                       input logic         cin);
    logic [N-1:0] s;
    logic         c;
    logic         ovf;
    s = '0;
    c = cin;
    for (int unsigned i = 0; i < N; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    ovf = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    return {ovf, c, s};
  endfunction

  always_comb begin
    slice_a = a_reg[int'(idx)*N +: N];
    slice_b = b_reg[int'(idx)*N +: N];
    {slice_ovf, slice_cout, slice_sum} = rca(slice_a, slice_b, carry_reg);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            // subtract is A + ~B + 1: the +1 enters as the first carry-in
            carry_reg <= sub;
            idx       <= '0;
            result    <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          result[int'(idx)*N +: N] <= slice_sum;
          carry_reg                <= slice_cout;
          if (idx == IDX_W'(K - 1)) begin
            // top slice: its carry and overflow describe the whole word;
            // idx stays put rather than wrapping
            cout     <= slice_cout;
            overflow <= slice_ovf;
            state    <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
